// File: rtl/uart_pkg.sv
// Shared UART definitions for rxuart and txuart: receiver state encodings,
// frame width and per-board default baud divisors.
`timescale 1ns/1ps
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // 115200 baud at the two board clocks (100 MHz, 27 MHz)
    localparam logic [23:0] CLOCKS_PER_BAUD_100MHZ = 24'd868;
    localparam logic [23:0] CLOCKS_PER_BAUD_27MHZ  = 24'd234;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rxuart_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to
// RESET_VAL so an idle-high line never looks like a start bit out of reset.
`timescale 1ns/1ps
module rxuart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_r;

    // Metastability chain
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_r <= RESET_VAL;
            o_q    <= RESET_VAL;
        end else begin
            meta_r <= i_d;
            o_q    <= meta_r;
        end
    end

endmodule

// File: rtl/rxuart.sv
// 8N1 UART receiver with mid-bit sampling and break handling.
// Optional stop-bit error strobe o_frame_err enabled by RXUART_FRAME_ERR_EN.
`timescale 1ns/1ps
module rxuart
    import uart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_uart_rx,
    output logic                      o_wr,
    output logic [UART_DATA_BITS-1:0] o_data
`ifdef RXUART_FRAME_ERR_EN
    ,
    output logic                      o_frame_err
`endif
);

    localparam logic [23:0] HALF_LOAD = (CLOCKS_PER_BAUD >> 1) - 24'd1;
    localparam logic [23:0] BAUD_LOAD = CLOCKS_PER_BAUD - 24'd1;
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state_r;
    rx_state_t                 state_next_s;
    logic [23:0]               baud_cnt_r;
    logic [2:0]                bit_idx_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic                      sample_s;
    logic                      deliver_s;
`ifdef RXUART_FRAME_ERR_EN
    logic                      frame_bad_s;
`endif

    rxuart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_uart_rx),
        .o_q     (rx_s)
    );

    assign sample_s = (baud_cnt_r == 24'd0);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RX_IDLE: begin
                if (!rx_s) state_next_s = RX_START;
                else       state_next_s = RX_IDLE;
            end
            RX_START: begin
                if (sample_s) state_next_s = rx_s ? RX_IDLE : RX_DATA;
                else          state_next_s = RX_START;
            end
            RX_DATA: begin
                if (sample_s && (bit_idx_r == LAST_BIT)) state_next_s = RX_STOP;
                else                                     state_next_s = RX_DATA;
            end
            RX_STOP: begin
                // A low stop bit may be the start of a break; wait it out
                if (sample_s) state_next_s = rx_s ? RX_IDLE : RX_BREAK;
                else          state_next_s = RX_STOP;
            end
            RX_BREAK: begin
                if (rx_s) state_next_s = RX_IDLE;
                else      state_next_s = RX_BREAK;
            end
            default: state_next_s = RX_IDLE;
        endcase
    end

    // Output decode: byte delivery and stop-bit error at the stop sample
    always_comb begin
        deliver_s = 1'b0;
`ifdef RXUART_FRAME_ERR_EN
        frame_bad_s = 1'b0;
`endif
        case (state_r)
            RX_STOP: begin
                if (sample_s) begin
`ifdef RXUART_FRAME_ERR_EN
                    deliver_s   = rx_s;
                    frame_bad_s = !rx_s;
`else
                    deliver_s   = 1'b1;
`endif
                end else begin
                    deliver_s = 1'b0;
                end
            end
            default: deliver_s = 1'b0;
        endcase
    end

    // Baud counter, bit index, shift register and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            baud_cnt_r  <= 24'd0;
            bit_idx_r   <= 3'd0;
            shift_r     <= '0;
            o_wr        <= 1'b0;
            o_data      <= '0;
`ifdef RXUART_FRAME_ERR_EN
            o_frame_err <= 1'b0;
`endif
        end else begin
            case (state_r)
                RX_IDLE: begin
                    baud_cnt_r <= rx_s ? 24'd0 : HALF_LOAD;
                    bit_idx_r  <= 3'd0;
                end
                RX_START, RX_STOP: begin
                    baud_cnt_r <= sample_s ? BAUD_LOAD : (baud_cnt_r - 24'd1);
                end
                RX_DATA: begin
                    baud_cnt_r <= sample_s ? BAUD_LOAD : (baud_cnt_r - 24'd1);
                    if (sample_s) begin
                        shift_r[bit_idx_r] <= rx_s;
                        bit_idx_r          <= bit_idx_r + 3'd1;
                    end
                end
                default: begin
                    baud_cnt_r <= 24'd0;
                end
            endcase
            o_wr <= deliver_s;
            if (deliver_s) o_data <= shift_r;
`ifdef RXUART_FRAME_ERR_EN
            o_frame_err <= frame_bad_s;
`endif
        end
    end

endmodule

// File: tb/tb_rxuart.sv
// Self-checking bench for rxuart at CLOCKS_PER_BAUD=8; a scoreboard queue
// holds expected strobes, matched by a negedge monitor.
`timescale 1ns/1ps
module tb_rxuart;

    localparam int CPB = 8;

    typedef struct {
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       o_wr;
    logic [7:0] o_data;
    logic       ferr_s;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   wr_cyc = -1;
    int   start_cyc = 0;
    logic [7:0] model_data = 8'h00;
    exp_t exp_q[$];
    vec_t vecs[6];

    rxuart #(.CLOCKS_PER_BAUD(24'd8)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_uart_rx   (rx),
        .o_wr        (o_wr),
        .o_data      (o_data)
`ifdef RXUART_FRAME_ERR_EN
        ,
        .o_frame_err (ferr_s)
`endif
    );
`ifndef RXUART_FRAME_ERR_EN
    assign ferr_s = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (o_wr || ferr_s) begin
            n_vec++;
            wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: wr=%0b ferr=%0b data=%02h, required no strobe", o_wr, ferr_s, o_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_wr !== !e.ferr || ferr_s !== e.ferr || o_data !== e.data) begin
                    n_err++;
                    $display("FAIL strobe: wr=%0b ferr=%0b data=%02h, required wr=%0b ferr=%0b data=%02h",
                             o_wr, ferr_s, o_data, !e.ferr, e.ferr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        for (int i = 0; i < gap; i++) send_bit(1'b1);
    endtask

    task automatic push_wr(input logic [7:0] d);
        exp_q.push_back('{1'b0, d});
        model_data = d;
    endtask

    task automatic push_bad(input logic [7:0] d);
`ifdef RXUART_FRAME_ERR_EN
        exp_q.push_back('{1'b1, model_data});
`else
        push_wr(d);
`endif
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        string hello;
        hello = "Hello, World! \n\r";

        vecs[0] = '{8'hA5, 1'b0, 2, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 1'b0, 8'hFF};
        vecs[3] = '{8'h5A, 1'b1, 1, 1'b0, 8'h5A};
        vecs[4] = '{8'h81, 1'b1, 0, 1'b0, 8'h81};
        vecs[5] = '{8'h7E, 1'b1, 1, 1'b0, 8'h7E};
`ifdef RXUART_FRAME_ERR_EN
        vecs[0].exp_ferr = 1'b1;
        vecs[0].exp_data = 8'h48;
`endif

        // Reset state
        repeat (4) tick();
        check("reset_wr", o_wr, 1'b0);
        check("reset_data", o_data, 8'h00);
        check("reset_ferr", ferr_s, 1'b0);
        rst = 1'b0;
        repeat (3) tick();

        // Single "H" with exact latency from the pin edge
        push_wr(8'h48);
        send_frame(8'h48, 1'b1, 1);
        drain("H_drain");
        check("H_latency", wr_cyc - start_cyc, 79);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].exp_ferr) exp_q.push_back('{1'b1, vecs[i].exp_data});
            else                  exp_q.push_back('{1'b0, vecs[i].exp_data});
            if (!vecs[i].exp_ferr) model_data = vecs[i].exp_data;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap);
        end
        drain("table_drain");
        check("table_hold_data", o_data, model_data);

        // Back-to-back greeting stream
        for (int i = 0; i < 16; i++) begin
            push_wr(hello[i]);
            send_frame(hello[i], 1'b1, 0);
        end
        send_bit(1'b1);
        drain("hello_drain");

        // 3-cycle glitch must not produce anything
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (40) tick();
        check("glitch_data", o_data, model_data);
        push_wr(8'hC3);
        send_frame(8'hC3, 1'b1, 1);
        drain("after_glitch");

        // Break: 40 bit times low, at most one strobe, then a clean frame
        push_bad(8'h00);
        for (int i = 0; i < 40; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        drain("break_drain");
        push_wr(8'h3C);
        send_frame(8'h3C, 1'b1, 1);
        drain("after_break");
        check("after_break_data", o_data, 8'h3C);

        // Reset during bit 4 of 0xFF
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_data = 8'h00;
        check("midreset_wr", o_wr, 1'b0);
        check("midreset_data", o_data, 8'h00);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (20) tick();
        check("midreset_quiet", o_data, 8'h00);
        push_wr(8'h0F);
        send_frame(8'h0F, 1'b1, 1);
        drain("after_reset");
        check("after_reset_data", o_data, 8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rxuart.md
# rxuart

UART receiver, the receiving end of the team's 8N1 serial link. Synchronizes the asynchronous `i_uart_rx` line, detects a start bit, samples eight data bits LSB-first at mid-bit, checks the stop bit, and presents each byte with a one-cycle strobe. Used to loop back and check `helloworld` output in simulation and hardware, and as the input path of future command/echo designs.

## Interface
Parameters:
- `CLOCKS_PER_BAUD`, default 24'd868 (100 MHz / 115200), 24-bit clocks per bit; legal range 8..2^24-1.

Ports:
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  reset, synchronous and active-high.
- `i_uart_rx`  in  1  asynchronous serial line; idle high.
- `o_wr`  out  1  one-cycle strobe: `o_data` holds a newly received byte.
- `o_data`  out  8  last received byte; held until the next `o_wr`.
- `o_frame_err`  out  1  one-cycle strobe on a bad stop bit. Present only with `RXUART_FRAME_ERR_EN`.

## Operation
- Input path: 2-flop synchronizer, both flops reset/initialised to 1. `rx_s` denotes the synchronized line.
- Baud counter: 24-bit down-counter; a sample is taken on the cycle it reaches 0, then it reloads `CLOCKS_PER_BAUD-1`.
- States: `RX_IDLE`, `RX_START`, `RX_DATA` (3-bit bit index 0..7), `RX_STOP`, `RX_BREAK`.
- `RX_IDLE`: on `rx_s==0` load counter with `CLOCKS_PER_BAUD/2 - 1` (integer floor), go `RX_START`.
- `RX_START`: at sample, `rx_s==1` is a false start -> `RX_IDLE`, no output; `rx_s==0` -> `RX_DATA`, index 0.
- `RX_DATA`: at each sample shift `rx_s` into bit [index] (LSB first); after index 7 -> `RX_STOP`.
- `RX_STOP`: at sample, `rx_s==1` -> register byte into `o_data`, pulse `o_wr`, -> `RX_IDLE`. `rx_s==0` -> behaviour per Configuration, then `RX_BREAK`.
- `RX_BREAK`: wait until `rx_s==1`, then -> `RX_IDLE`. Prevents a held-low (break) line from being decoded as `8'h00` frames.
- Reset values: `o_wr=0`, `o_data=8'h00`, `o_frame_err=0`, state `RX_IDLE`, counter 0, synchronizer 2'b11.
- Reset mid-frame: frame abandoned, no strobe, `RX_IDLE` on the next cycle.
- `o_wr` and `o_frame_err` are never high together and never high for two consecutive cycles.

## Timing
- Let t be the first cycle with `rx_s==0` in `RX_IDLE` (2 cycles after the pin falls). Let H = `CLOCKS_PER_BAUD/2`.
- Start sample at cycle t+H. Data bit n at t+H+(n+1)·`CLOCKS_PER_BAUD`. Stop sample at t+H+9·`CLOCKS_PER_BAUD`.
- `o_wr` and the new `o_data` are visible in the cycle after the stop sample. Total pin-to-strobe latency is t+H+9·CPB+1 relative to the synchronized edge.
- Back-to-back frames: a new start bit is accepted from the cycle the receiver re-enters `RX_IDLE`, i.e. before the end of the stop bit. This tolerates transmitter clock up to ~4% fast.
- No backpressure: the consumer must take `o_data` before the next `o_wr`. The minimum spacing is 9.5 bit times.

## Configuration
- `RXUART_FRAME_ERR_EN` defined:
  - `o_frame_err` port exists.
  - On a stop bit `==0`: `o_frame_err` pulses for one cycle, `o_wr` is suppressed, and `o_data` is unchanged.
- Not defined:
  - No `o_frame_err` port.
  - The stop bit is not checked for delivery: `o_wr` pulses and `o_data` updates regardless of its value.
  - The stop=0 case still enters `RX_BREAK`.

## Structure
- Shared package `uart_pkg`, also used by `txuart`, holds:
  - state encodings (`RX_*`);
  - `UART_DATA_BITS=8`;
  - default `CLOCKS_PER_BAUD` constants for the 100 MHz and 27 MHz boards.
- One sub-module, `rxuart_sync`: a 2-flop synchronizer with parameterised reset value 1.
- Everything else is inline in `rxuart`.

## Test plan
All scenarios use `CLOCKS_PER_BAUD=8`.
- Send `8'h48` ("H"), 8N1 -> exactly one `o_wr`, `o_data==8'h48`, at t+4+72+1 cycles.
- Send the 16-byte `"Hello, World! \n\r"` stream back-to-back from `txuart` -> 16 `o_wr` pulses, bytes in order, no `o_frame_err`.
- 3-cycle low glitch on an idle line -> false start, no `o_wr`, state back to `RX_IDLE`.
- `8'hA5` sent with stop bit 0:
  - with `RXUART_FRAME_ERR_EN` -> one `o_frame_err`, no `o_wr`, `o_data` unchanged;
  - without it -> `o_wr` with `8'hA5`.
- Line held low for 40 bit times -> at most one strobe, then silence until the line goes high; the next valid frame `8'h3C` is received correctly.
- Assert `i_reset` during bit 4 of `8'hFF` -> no strobe, outputs at reset values. The following `8'h0F` is received correctly.
